// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : sequential ALU with a valid/ready handshake on both sides.
//
// One operation is in flight at a time. Logic, arithmetic, compare, shift and
// no-op codes finish in one cycle. When ALU_SEQ_MUL_EN is defined, code 1010
// is an unsigned shift-add multiply that takes W cycles in BUSY. Without that
// macro the multiplier and BUSY state are absent and 1010 behaves as a no-op.
//
// Configuration macro: ALU_SEQ_MUL_EN (undefined by default)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/B/ALUctr are valid this cycle
//   in_ready   block is idle and will accept an operation
//   A, B       W-bit two's complement operands
//   ALUctr     4-bit operation select
//   out_valid  ALUout and flags are valid
//   out_ready  consumer takes the result on this edge
//   ALUout     registered result
//   less, of, zf, cf  registered flags
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   ALUctr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ALUout,
  output logic         less,
  output logic         of,
  output logic         zf,
  output logic         cf
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t r_state;
  state_t w_state_next;

  logic w_accept;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the input operands so the
  // result can be registered on the accept edge itself.
  // ---------------------------------------------------------------------------
  logic          w_sub;
  logic [W-1:0]  w_bx;
  logic [W:0]    w_sum;
  logic          w_add_of;
  logic [SW-1:0] w_shamt;
  logic [W:0]    w_shl;
  logic signed [W:0] w_sra;
  logic [W-1:0]  w_res;
  logic          w_less;
  logic          w_of;
  logic          w_zf;
  logic          w_cf;

  always_comb begin
    w_sub    = (ALUctr == 4'b0001) || (ALUctr == 4'b0110) || (ALUctr == 4'b0111);
    w_bx     = B ^ {W{w_sub}};
    w_sum    = {1'b0, A} + {1'b0, w_bx} + {{W{1'b0}}, w_sub};
    // Overflow when both addends share a sign that the sum does not.
    w_add_of = (A[W-1] == w_bx[W-1]) && (w_sum[W-1] != A[W-1]);
    w_shamt  = B[SW-1:0];
    // The extra bit on each shift catches the last bit shifted out.
    w_shl    = {1'b0, A} << w_shamt;
    w_sra    = $signed({A, 1'b0}) >>> w_shamt;

    w_res  = '0;
    w_less = 1'b0;
    w_of   = 1'b0;
    w_zf   = 1'b0;
    w_cf   = 1'b0;

    case (ALUctr)
      4'b0000, 4'b0001: begin
        w_res = w_sum[W-1:0];
        w_cf  = w_sum[W];
        w_of  = w_add_of;
        w_zf  = (w_sum[W-1:0] == '0);
      end
      4'b0010: begin
        w_res = ~A;
        w_zf  = (~A == '0);
      end
      4'b0011: begin
        w_res = A & B;
        w_zf  = ((A & B) == '0);
      end
      4'b0100: begin
        w_res = A | B;
        w_zf  = ((A | B) == '0);
      end
      4'b0101: begin
        w_res = A ^ B;
        w_zf  = ((A ^ B) == '0);
      end
      4'b0110: begin
        // Flags describe the internal difference, result is the signed compare.
        w_cf   = w_sum[W];
        w_of   = w_add_of;
        w_zf   = (w_sum[W-1:0] == '0);
        w_less = w_sum[W-1] ^ w_add_of;
        w_res  = {{(W-1){1'b0}}, w_sum[W-1] ^ w_add_of};
      end
      4'b0111: begin
        w_cf  = w_sum[W];
        w_of  = w_add_of;
        w_zf  = (w_sum[W-1:0] == '0);
        w_res = {{(W-1){1'b0}}, (w_sum[W-1:0] == '0)};
      end
      4'b1000: begin
        w_res = w_shl[W-1:0];
        w_cf  = w_shl[W];
        w_zf  = (w_shl[W-1:0] == '0);
      end
      4'b1001: begin
        w_res = w_sra[W:1];
        w_cf  = (w_shamt == '0) ? 1'b0 : w_sra[0];
        w_zf  = (w_sra[W:1] == '0);
      end
      default: begin
        // Unused codes (and MUL, which is handled by the iterative path) leave
        // everything at zero.
        w_res = '0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative unsigned multiplier: one partial product per BUSY cycle.
  // ---------------------------------------------------------------------------
  logic            w_is_mul;
  logic            w_mul_last;
  logic [2*W-1:0]  w_acc_next;
  logic [2*W-1:0]  r_mc;
  logic [W-1:0]    r_mp;
  logic [2*W-1:0]  r_acc;
  logic [SW-1:0]   r_cnt;

  assign w_is_mul   = (ALUctr == 4'b1010);
  assign w_mul_last = (r_state == BUSY) && (r_cnt == SW'(W - 1));
  assign w_acc_next = r_acc + (r_mp[0] ? r_mc : '0);
`endif

  assign w_accept  = in_valid && (r_state == IDLE);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          w_state_next = w_is_mul ? BUSY : DONE;
`else
          w_state_next = DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        if (w_mul_last) begin
          w_state_next = DONE;
        end
      end
`endif
      DONE: begin
        // Returning to IDLE first means no accept can share the handshake edge.
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result and flag registers (held in DONE until the handshake)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUout <= '0;
      less   <= 1'b0;
      of     <= 1'b0;
      zf     <= 1'b0;
      cf     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mc   <= '0;
      r_mp   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
`endif
    end else begin
`ifdef ALU_SEQ_MUL_EN
      if (w_accept && w_is_mul) begin
        r_mc  <= {{W{1'b0}}, A};
        r_mp  <= B;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        ALUout <= w_res;
        less   <= w_less;
        of     <= w_of;
        zf     <= w_zf;
        cf     <= w_cf;
      end else if (r_state == BUSY) begin
        r_acc <= w_acc_next;
        r_mc  <= r_mc << 1;
        r_mp  <= r_mp >> 1;
        r_cnt <= r_cnt + 1'b1;
        if (w_mul_last) begin
          ALUout <= w_acc_next[W-1:0];
          cf     <= |w_acc_next[2*W-1:W];
          zf     <= (w_acc_next[W-1:0] == '0);
          of     <= 1'b0;
          less   <= 1'b0;
        end
      end
`else
      if (w_accept) begin
        ALUout <= w_res;
        less   <= w_less;
        of     <= w_of;
        zf     <= w_zf;
        cf     <= w_cf;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq (W=8). The driver pushes the
// reference model's answer when an operation is accepted; an independent
// monitor pops and compares whenever out_valid rises, and checks that the
// result stays stable while it is held in DONE.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALUctr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUout;
  logic         less;
  logic         of;
  logic         zf;
  logic         cf;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUctr    (ALUctr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .less      (less),
    .of        (of),
    .zf        (zf),
    .cf        (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic       less;
    logic       of;
    logic       zf;
    logic       cf;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;   // 0 random, 1 force low, 2 force high

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 1) out_ready = 1'b0;
    else                    out_ready = 1'b1;
  end

  // Reference model from the arithmetic meaning of each code.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    exp_t e;
    int ua, ub, sa, sb, s, t;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); s = ub % W;
    e.a = a; e.b = b; e.op = op;
    e.res = 8'h00; e.less = 0; e.of = 0; e.zf = 0; e.cf = 0; e.lat = 1; e.acc_cyc = 0;
    case (op)
      4'd0: begin
        t = ua + ub; e.res = 8'(t % 256); e.cf = (t >= 256);
        e.of = (sa + sb > 127) || (sa + sb < -128); e.zf = (e.res == 0);
      end
      4'd1: begin
        e.res = 8'((ua - ub + 256) % 256); e.cf = (ua >= ub);
        e.of = (sa - sb > 127) || (sa - sb < -128); e.zf = (e.res == 0);
      end
      4'd2: begin e.res = ~a;    e.zf = (e.res == 0); end
      4'd3: begin e.res = a & b; e.zf = (e.res == 0); end
      4'd4: begin e.res = a | b; e.zf = (e.res == 0); end
      4'd5: begin e.res = a ^ b; e.zf = (e.res == 0); end
      4'd6, 4'd7: begin
        e.cf = (ua >= ub);
        e.of = (sa - sb > 127) || (sa - sb < -128);
        e.zf = (ua == ub);
        if (op == 4'd6) begin e.less = (sa < sb); e.res = (sa < sb) ? 8'd1 : 8'd0; end
        else            e.res = (ua == ub) ? 8'd1 : 8'd0;
      end
      4'd8: begin
        e.res = 8'((ua << s) % 256);
        e.cf  = (s == 0) ? 1'b0 : 1'((ua >> (W - s)) & 1);
        e.zf  = (e.res == 0);
      end
      4'd9: begin
        e.res = 8'((sa >>> s) & 255);
        e.cf  = (s == 0) ? 1'b0 : 1'((ua >> (s - 1)) & 1);
        e.zf  = (e.res == 0);
      end
`ifdef ALU_SEQ_MUL_EN
      4'd10: begin
        t = ua * ub; e.res = 8'(t % 256); e.cf = (t > 255);
        e.zf = (e.res == 0); e.lat = W + 1;
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Monitor
  logic       prev_valid = 1'b0;
  exp_t       cur;
  logic [7:0] held_res;
  logic [3:0] held_flags;

  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid act=1 req=0 res=%02h", ALUout);
      end else begin
        cur = exp_q.pop_front();
        $display("TXN op=%h A=%02h B=%02h -> res=%02h l=%0d o=%0d z=%0d c=%0d lat=%0d",
                 cur.op, cur.a, cur.b, ALUout, less, of, zf, cf, cyc - cur.acc_cyc + 1);
        if (ALUout !== cur.res || less !== cur.less || of !== cur.of ||
            zf !== cur.zf || cf !== cur.cf || (cyc - cur.acc_cyc + 1) != cur.lat) begin
          failures++;
          $display("FAIL result op=%h A=%02h B=%02h act res=%02h lczf=%b%b%b%b lat=%0d req res=%02h lczf=%b%b%b%b lat=%0d",
                   cur.op, cur.a, cur.b, ALUout, less, cf, zf, of, cyc - cur.acc_cyc + 1,
                   cur.res, cur.less, cur.cf, cur.zf, cur.of, cur.lat);
        end
      end
      held_res   = ALUout;
      held_flags = {less, of, zf, cf};
    end else if (out_valid && prev_valid) begin
      checks++;
      if (ALUout !== held_res || {less, of, zf, cf} !== held_flags || in_ready) begin
        failures++;
        $display("FAIL hold_stable act res=%02h flags=%b rdy=%b req res=%02h flags=%b rdy=0",
                 ALUout, {less, of, zf, cf}, in_ready, held_res, held_flags);
      end
    end
    prev_valid = out_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout act=in_ready0 req=in_ready1");
      return;
    end
    A = a; B = b; ALUctr = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e = model(a, b, op);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    // Scramble inputs to show the operation in flight does not depend on them.
    A = 8'($urandom); B = 8'($urandom); ALUctr = 4'($urandom);
  endtask

  task automatic wait_valid(input string name, input logic chk_ready);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      if (chk_ready) check({name, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUctr = '0; out_ready = 1'b0;
    #1;
    check("reset_outs", {22'd0, out_valid, in_ready, ALUout, less, of, zf, cf},
          {22'd0, 1'b0, 1'b1, 8'h00, 4'b0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    do_op(8'h7F, 8'h01, 4'b0000);
    do_op(8'h05, 8'h05, 4'b0001);
    do_op(8'h05, 8'h05, 4'b0111);
    do_op(8'h80, 8'h01, 4'b0110);
    do_op(8'h01, 8'h80, 4'b0110);
    do_op(8'h81, 8'h00, 4'b1000);
    do_op(8'h81, 8'h01, 4'b1001);
    do_op(8'hC3, 8'h0F, 4'b1001);
    do_op(8'h12, 8'h34, 4'b1111);
    do_op(8'h10, 8'h11, 4'b1010);
`ifdef ALU_SEQ_MUL_EN
    rdy_mode = 2;
    do_op(8'h10, 8'h11, 4'b1010);
    wait_valid("mul", 1'b1);
    rdy_mode = 0;
`endif

    // Hold in DONE with out_ready low; an in_valid pulse must be ignored.
    rdy_mode = 1;
    do_op(8'h3C, 8'h0F, 4'b0101);
    @(negedge clk);
    wait_valid("hold", 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin A = 8'h01; B = 8'h02; ALUctr = 4'b0000; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("release_idle", {30'd0, in_ready, out_valid}, {30'd0, 2'b10});
    rdy_mode = 0;

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      do_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    end

    // Reset during an operation (mid-MUL when present, otherwise in DONE)
    rdy_mode = 1;
`ifdef ALU_SEQ_MUL_EN
    do_op(8'hAB, 8'hCD, 4'b1010);
`else
    do_op(8'hAB, 8'hCD, 4'b0000);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid_op", {22'd0, out_valid, in_ready, ALUout, less, of, zf, cf},
          {22'd0, 1'b0, 1'b1, 8'h00, 4'b0000});
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      check("no_valid_after_reset", {31'd0, out_valid}, 32'd0);
    end

    // Drain
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("drain", exp_q.size(), 32'd0);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter W, default 8: operand/result width, legal values 4..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and opcode are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-006 SHALL have port A, input, W bits: operand A, two's complement.
REQ-007 SHALL have port B, input, W bits: operand B, two's complement.
REQ-008 SHALL have port ALUctr, input, 4 bits: operation select.
REQ-009 SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port ALUout, output, W bits: registered result.
REQ-012 SHALL have ports less, of, zf, cf, each output, 1 bit: registered flags.

Function
REQ-013 SHALL implement a FSM with states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept an operation on a rising edge where in_valid=1 and in_ready=1; A, B and ALUctr SHALL be captured on that edge.
REQ-015 SHALL support these ALUctr codes: 0000 A+B; 0001 A-B; 0010 ~A; 0011 A&B; 0100 A|B; 0101 A^B; 0110 signed A<B (result 1/0); 0111 A==B (result 1/0); 1000 A<<B[s]; 1001 arithmetic A>>>B[s]; 1010 MUL. Here s = clog2(W) low bits of B.
REQ-016 SHALL, for ADD and SUB, compute {cf,ALUout} = A + (B^{W{sub}}) + sub in W+1 bits. of = signed overflow. SUB cf is carry-out, not borrow.
REQ-017 SHALL, for 0110 and 0111, compute the internal difference A-B and drive cf, of and zf from that difference; less = diff[W-1] XOR of.
REQ-018 SHALL, for all operations other than 0110 and 0111, set zf = (ALUout==0); less SHALL be 0 except for 0110.
REQ-019 SHALL set cf=0 and of=0 for the logic ops (0010..0101). For shifts, cf = last bit shifted out (0 if shift amount is 0) and of=0.
REQ-020 SHALL complete non-MUL ops in 1 cycle: accept edge moves the FSM IDLE->DONE, and out_valid=1 with the result on the following cycle.
REQ-021 SHALL compute MUL as an unsigned iterative shift-add of W cycles: IDLE->BUSY on accept, BUSY->DONE after W cycles, so out_valid rises W+1 cycles after accept. ALUout = low W bits of the product; cf = OR of the high W bits; of=0.
REQ-022 SHALL hold ALUout and flags stable in DONE while out_ready=0, and move DONE->IDLE on an edge with out_valid=1 and out_ready=1.
REQ-023 SHALL ignore in_valid in BUSY and DONE. No new operation is accepted on the same edge as a result handshake; in_ready rises the cycle after DONE->IDLE.
REQ-024 SHALL treat codes 1011..1111 as legal no-ops: complete in 1 cycle with ALUout=0 and all flags 0.
REQ-025 SHALL change A, B or ALUctr after the accept edge without affecting an operation in flight.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state=IDLE, out_valid=0, ALUout=0 and less=of=zf=cf=0; in_ready SHALL be 1 after reset.
REQ-027 SHALL, on reset asserted during BUSY or DONE, abort the operation and produce no out_valid for it after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro ALU_SEQ_MUL_EN is defined, implement MUL (1010) per REQ-021 and include the BUSY state.
REQ-029 SHALL, when ALU_SEQ_MUL_EN is undefined, omit the multiplier and BUSY state and treat 1010 as a no-op per REQ-024; all ops then have 1-cycle latency.

Verification (W=8)
REQ-030 SHALL cover: A=0x7F, B=0x01, ALUctr=0000 -> ALUout=0x80, of=1, cf=0, zf=0, out_valid one cycle after accept.
REQ-031 SHALL cover: A=0x05, B=0x05, ALUctr=0001 -> ALUout=0x00, zf=1, cf=1, of=0; and ALUctr=0111 -> ALUout=0x01.
REQ-032 SHALL cover: A=0x80 (-128), B=0x01, ALUctr=0110 -> ALUout=0x01, less=1; and A=0x01, B=0x80 -> ALUout=0x00, less=0.
REQ-033 SHALL cover, with MUL_EN: A=0x10, B=0x11, ALUctr=1010 -> ALUout=0x10, cf=1; out_valid 9 cycles after accept; in_ready=0 throughout.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> ALUout/flags stable, in_valid pulses ignored; then out_ready=1 -> IDLE with in_ready=1 the next cycle.
REQ-035 SHALL cover: rst_n pulsed low mid-MUL (cycle 4 of BUSY) -> outputs immediately 0, in_ready=1, no out_valid afterwards.
